vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, meaning clocks per line.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, meaning clocks per line with HSync high.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, meaning lines per frame with VSync high.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive error-free frames needed for lock.
REQ-006 SHALL have port i_Clk, input, 1, the single clock for all logic.
REQ-007 SHALL have port Reset, input, 1, reset that is asynchronous and active-high.
REQ-008 SHALL have port i_HSync, input, 1, horizontal sync (high = active columns).
REQ-009 SHALL have port i_VSync, input, 1, vertical sync (high = active rows).
REQ-010 SHALL have port o_Col_Count, output, 10, recovered column index.
REQ-011 SHALL have port o_Row_Count, output, 10, recovered row index.
REQ-012 SHALL have port o_Active, output, 1, high when o_Col_Count < ACTIVE_COLS and o_Row_Count < ACTIVE_ROWS and locked.
REQ-013 SHALL have port o_Frame_Start, output, 1, one-cycle pulse per VSync rising edge.
REQ-014 SHALL have port o_Locked, output, 1, high while FSM in LOCKED.
REQ-015 SHALL have port o_Err_Pulse, output, 1, one-cycle pulse per timing error detected while LOCKED.
REQ-016 SHALL have port o_Err_Count, output, 8, saturating count of o_Err_Pulse events.

Function
REQ-017 SHALL register i_HSync and i_VSync once; edges detected by comparing registered value with its one-cycle-delayed copy.
REQ-018 HSync rise detected -> o_Col_Count = 0 on next clock; i.e. o_Col_Count reads 0 on the 2nd rising i_Clk edge after i_HSync sampled high.
REQ-019 Otherwise o_Col_Count increments by 1 per clock, wrapping TOTAL_COLS-1 -> 0.
REQ-020 VSync rise detected -> o_Row_Count = 0, same latency as REQ-018; simultaneous HSync rise -> col and row both 0.
REQ-021 Otherwise o_Row_Count increments on each HSync rise, wrapping TOTAL_ROWS-1 -> 0.
REQ-022 o_Frame_Start SHALL pulse high for exactly one clock, coincident with o_Row_Count loading 0.
REQ-023 Line error: HSync rise with line length != TOTAL_COLS clocks, or HSync high run != ACTIVE_COLS clocks.
REQ-024 Missing-sync error: TOTAL_COLS clocks elapse after last HSync rise without a new rise; flagged once, internal line counter saturates at 1023.
REQ-025 Frame error: VSync rise with line count since previous VSync rise != TOTAL_ROWS, or VSync high run != ACTIVE_ROWS lines.
REQ-026 FSM states SEARCH, VERIFY, LOCKED; o_Locked = (state == LOCKED).
REQ-027 SEARCH: errors ignored; first VSync rise -> VERIFY, good-frame count = 0.
REQ-028 VERIFY: VSync rise closing an error-free frame -> count+1; count reaching LOCK_FRAMES -> LOCKED on that clock.
REQ-029 VERIFY: any error -> count = 0, stay VERIFY; no o_Err_Pulse.
REQ-030 LOCKED: any error -> o_Err_Pulse one clock, o_Err_Count +1 (holds at 255), state -> SEARCH.
REQ-031 Multiple error conditions in the same clock SHALL produce a single o_Err_Pulse and single increment.
REQ-032 Column/row counters SHALL keep running in all FSM states; only o_Active is gated by lock.

Reset
REQ-033 Reset high SHALL asynchronously force state SEARCH, all counters 0, sync registers 0, all outputs 0.
REQ-034 Reset assertion mid-frame SHALL discard measurements; lock reacquisition restarts from REQ-027 after release.

Verification
REQ-035 Nominal 800x525 timing from a sync generator, 4 frames -> o_Locked high right after 3rd VSync rise (1 SEARCH + 2 VERIFY), o_Active count per frame = 307200, o_Err_Count = 0.
REQ-036 Locked, one line shortened to 799 clocks -> single o_Err_Pulse, o_Err_Count = 1, o_Locked low next clock, relock after 3 further good VSync rises.
REQ-037 Locked, HSync stuck low -> one o_Err_Pulse 800 clocks after last rise, o_Col_Count keeps wrapping 799 -> 0.
REQ-038 Force 300 LOCKED error events -> o_Err_Count saturates at 255.
REQ-039 Simultaneous HSync/VSync rise -> col = 0, row = 0, o_Frame_Start one clock, 2 clocks after sample.
REQ-040 Reset asserted mid-line while locked -> outputs 0 immediately (no clock), o_Locked low until relock.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Recovers column/row position and lock status from a VGA HSync/VSync pair.
// Latency: counters load 2 clocks after a sync edge is sampled; no backpressure (free-running stream).
module vga_sync_decoder #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_Clk,
    input  logic       Reset,
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
    output logic       o_Frame_Start,
    output logic       o_Locked,
    output logic       o_Err_Pulse,
    output logic [7:0] o_Err_Count
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [9:0]  COLS_M1  = 10'(TOTAL_COLS - 1);
    localparam logic [9:0]  ROWS_M1  = 10'(TOTAL_ROWS - 1);
    localparam logic [10:0] ROWS_W   = 11'(TOTAL_ROWS);
    localparam logic [9:0]  ACOLS    = 10'(ACTIVE_COLS);
    localparam logic [9:0]  AROWS    = 10'(ACTIVE_ROWS);
    localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);
    localparam logic [9:0]  SAT      = 10'h3FF;

    logic       hs_q, hs_d, hs_dly_q, hs_dly_d;
    logic       vs_q, vs_d, vs_dly_q, vs_dly_d;
    logic       hs_rise, vs_rise;

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic       fs_q, fs_d;

    logic [9:0] line_len_q, line_len_d;
    logic [9:0] hi_run_q, hi_run_d;
    logic [9:0] frame_lines_q, frame_lines_d;
    logic [9:0] vs_hi_q, vs_hi_d;

    logic       line_err, miss_err, frame_err, any_err;

    state_t     state_q, state_d;
    logic [7:0] good_cnt_q, good_cnt_d;
    logic       clean_q, clean_d;
    logic       err_pulse_q, err_pulse_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    assign hs_rise = hs_q & ~hs_dly_q;
    assign vs_rise = vs_q & ~vs_dly_q;

    always_comb begin
        hs_d     = i_HSync;
        hs_dly_d = hs_q;
        vs_d     = i_VSync;
        vs_dly_d = vs_q;
    end

    // Position counters run in every FSM state; only o_Active depends on lock.
    always_comb begin
        col_d = col_q + 10'd1;
        if (hs_rise || col_q == COLS_M1) begin
            col_d = '0;
        end

        row_d = row_q;
        if (vs_rise) begin
            row_d = '0;
        end else if (hs_rise) begin
            row_d = (row_q == ROWS_M1) ? 10'd0 : row_q + 10'd1;
        end

        fs_d = vs_rise;
    end

    // Timing measurements, all saturating so a dead input cannot wrap back to a legal value.
    always_comb begin
        line_len_d = line_len_q;
        if (hs_rise) begin
            line_len_d = '0;
        end else if (line_len_q != SAT) begin
            line_len_d = line_len_q + 10'd1;
        end

        hi_run_d = hi_run_q;
        if (hs_rise) begin
            hi_run_d = 10'd1;
        end else if (hs_q && hi_run_q != SAT) begin
            hi_run_d = hi_run_q + 10'd1;
        end

        frame_lines_d = frame_lines_q;
        if (vs_rise) begin
            frame_lines_d = '0;
        end else if (hs_rise && frame_lines_q != SAT) begin
            frame_lines_d = frame_lines_q + 10'd1;
        end

        vs_hi_d = vs_hi_q;
        if (vs_rise) begin
            vs_hi_d = {9'd0, hs_rise};
        end else if (vs_q && hs_rise && vs_hi_q != SAT) begin
            vs_hi_d = vs_hi_q + 10'd1;
        end
    end

    // A VSync rise landing on a line start counts that line toward the closing frame.
    always_comb begin
        line_err  = hs_rise && (line_len_q != COLS_M1 || hi_run_q != ACOLS);
        miss_err  = !hs_rise && (line_len_q == COLS_M1);
        frame_err = vs_rise &&
                    ((({1'b0, frame_lines_q} + {10'd0, hs_rise}) != ROWS_W) ||
                     (vs_hi_q != AROWS));
        any_err   = line_err | miss_err | frame_err;
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        clean_d     = clean_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d    = VERIFY;
                    good_cnt_d = '0;
                    clean_d    = 1'b1;
                end
            end
            VERIFY: begin
                if (vs_rise) begin
                    clean_d = 1'b1;
                    if (any_err || !clean_q) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_q + 8'd1 >= LOCK_N) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + 8'd1;
                    end
                end else if (any_err) begin
                    good_cnt_d = '0;
                    clean_d    = 1'b0;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    err_pulse_d = 1'b1;
                    state_d     = SEARCH;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge i_Clk or posedge Reset) begin
        if (Reset) begin
            hs_q          <= 1'b0;
            hs_dly_q      <= 1'b0;
            vs_q          <= 1'b0;
            vs_dly_q      <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
            fs_q          <= 1'b0;
            line_len_q    <= '0;
            hi_run_q      <= '0;
            frame_lines_q <= '0;
            vs_hi_q       <= '0;
            state_q       <= SEARCH;
            good_cnt_q    <= '0;
            clean_q       <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            hs_q          <= hs_d;
            hs_dly_q      <= hs_dly_d;
            vs_q          <= vs_d;
            vs_dly_q      <= vs_dly_d;
            col_q         <= col_d;
            row_q         <= row_d;
            fs_q          <= fs_d;
            line_len_q    <= line_len_d;
            hi_run_q      <= hi_run_d;
            frame_lines_q <= frame_lines_d;
            vs_hi_q       <= vs_hi_d;
            state_q       <= state_d;
            good_cnt_q    <= good_cnt_d;
            clean_q       <= clean_d;
            err_pulse_q   <= err_pulse_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Locked      = (state_q == LOCKED);
    assign o_Active      = o_Locked && (col_q < ACOLS) && (row_q < AROWS);
    assign o_Frame_Start = fs_q;
    assign o_Err_Pulse   = err_pulse_q;
    assign o_Err_Count   = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder using a scaled-down 8x5 frame (5x3 active) so lock/relock runs stay short.
module tb_vga_sync_decoder;

    localparam int C  = 8;
    localparam int R  = 5;
    localparam int AC = 5;
    localparam int AR = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       hs, vs;
    logic [9:0] col, row;
    logic       act, fs, lk, ep;
    logic [7:0] ec;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .TOTAL_COLS (C),
        .TOTAL_ROWS (R),
        .ACTIVE_COLS(AC),
        .ACTIVE_ROWS(AR),
        .LOCK_FRAMES(2)
    ) dut (
        .i_Clk        (clk),
        .Reset        (rst),
        .i_HSync      (hs),
        .i_VSync      (vs),
        .o_Col_Count  (col),
        .o_Row_Count  (row),
        .o_Active     (act),
        .o_Frame_Start(fs),
        .o_Locked     (lk),
        .o_Err_Pulse  (ep),
        .o_Err_Count  (ec)
    );

    // Running totals sampled on the falling edge, away from input changes.
    int fs_cnt = 0, act_cnt = 0, ep_cnt = 0, ep_locked = 0, lk_rises = 0, lk_fs = 0;
    int lk_with_fs = 0;
    logic prev_lk = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            fs_cnt  = fs_cnt + int'(fs);
            act_cnt = act_cnt + int'(act);
            ep_cnt  = ep_cnt + int'(ep);
            if (ep && lk) ep_locked = ep_locked + 1;
            if (lk && !prev_lk) begin
                lk_rises   = lk_rises + 1;
                lk_fs      = fs_cnt;
                lk_with_fs = int'(fs);
            end
        end
        prev_lk = lk;
    end

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [9:0] col;
        logic [9:0] row;
        logic       fs;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int got, input int exp_v);
        n_chk = n_chk + 1;
        if (got == exp_v) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp_v);
    endtask

    task automatic drive(input logic h, input logic v);
        hs = h;
        vs = v;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int short_row);
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (!(r == short_row && c == C - 1)) drive(logic'(c < AC), logic'(r < AR));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int s_fs, s_act, s_ep, s_epl, s_lkr;
        int pulses, pulse_idx, bad_col;
        logic [9:0] prev_col;

        //               hs    vs    col     row     fs
        tbl[0]  = '{1'b0, 1'b0, 10'd1, 10'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 10'd2, 10'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 10'd0, 10'd0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 10'd1, 10'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 10'd2, 10'd0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 10'd3, 10'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 10'd0, 10'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 10'd1, 10'd1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 10'd2, 10'd1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 10'd0, 10'd2, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 10'd1, 10'd2, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 10'd2, 10'd0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 10'd0, 10'd1, 1'b0};

        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        @(posedge clk);
        #1;
        check("reset_outputs", int'({col, row, act, fs, lk, ep, ec}), 0);
        rst = 1'b0;

        // Edge-detect latency, simultaneous rise, off-line VSync rise.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].hs, tbl[i].vs);
            check($sformatf("vec%0d {col,row,fs,lk,ep}", i),
                  int'({col, row, fs, lk, ep}),
                  int'({tbl[i].col, tbl[i].row, tbl[i].fs, 2'b00}));
        end

        // Nominal acquisition: lock on the third VSync rise.
        do_reset();
        s_fs  = fs_cnt;
        s_lkr = lk_rises;
        run_frame(-1);
        run_frame(-1);
        run_frame(-1);
        s_act = act_cnt;
        s_ep  = ep_cnt;
        run_frame(-1);
        check("lock_rises", lk_rises - s_lkr, 1);
        check("lock_at_vsync_rise_no", lk_fs - s_fs, 3);
        check("lock_with_frame_start", lk_with_fs, 1);
        check("active_per_frame", act_cnt - s_act, AC * AR);
        check("nominal_err_pulses", ep_cnt - s_ep, 0);
        check("nominal_err_count", int'(ec), 0);

        // One short line while locked.
        s_ep  = ep_cnt;
        s_epl = ep_locked;
        run_frame(1);
        check("short_line_pulses", ep_cnt - s_ep, 1);
        check("short_line_err_count", int'(ec), 1);
        check("short_line_unlock", ep_locked - s_epl, 0);
        run_frame(-1);
        run_frame(-1);
        check("short_line_not_relocked", int'(lk), 0);
        run_frame(-1);
        check("short_line_relocked", int'(lk), 1);

        // HSync stuck low while locked.
        pulses    = 0;
        pulse_idx = -1;
        bad_col   = 0;
        prev_col  = col;
        for (int i = 0; i < 3 * C; i++) begin
            drive(1'b0, 1'b0);
            if (ep) begin
                pulses = pulses + 1;
                if (pulse_idx < 0) pulse_idx = i;
            end
            if (int'(col) != (int'(prev_col) + 1) % C) bad_col = bad_col + 1;
            prev_col = col;
        end
        check("stuck_pulses", pulses, 1);
        check("stuck_pulse_cycle", pulse_idx, 1);
        check("stuck_col_wrap_errors", bad_col, 0);
        check("stuck_err_count", int'(ec), 2);

        // Asynchronous reset mid-line while locked.
        run_frame(-1);
        run_frame(-1);
        run_frame(-1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        check("pre_reset_locked", int'(lk), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({col, row, act, fs, lk, ep, ec}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hs  = 1'b0;
        vs  = 1'b0;
        run_frame(-1);
        run_frame(-1);
        check("post_reset_not_locked", int'(lk), 0);
        run_frame(-1);
        check("post_reset_relocked", int'(lk), 1);

        // 300 locked error events saturate the error counter.
        s_ep  = ep_cnt;
        s_epl = ep_locked;
        for (int i = 0; i < 300; i++) begin
            run_frame(1);
            if (i == 253) check("err_count_254", int'(ec), 254);
            run_frame(-1);
            run_frame(-1);
        end
        check("err_count_saturated", int'(ec), 255);
        check("sat_pulse_total", ep_cnt - s_ep, 300);
        check("sat_unlock_with_pulse", ep_locked - s_epl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
